// File: rtl/mbi5153_pkg.sv
// Shared types and helpers for the MBI5153 frame sequencer.
// Holds the FSM encoding, line-order mode codes and the address-width helper.
package mbi5153_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT_RDY,
    ST_ISSUE,
    ST_WAIT_LINE,
    ST_DONE
  } frame_state_t;

  localparam logic [1:0] MODE_SEQ = 2'd0;
  localparam logic [1:0] MODE_REV = 2'd1;
  localparam logic [1:0] MODE_ILV = 2'd2;

  // Bits needed to hold any address below span (ceil(log2)), never less than 1.
  function automatic int addr_width_of(input longint unsigned span);
    int w;
    w = 0;
    while ((longint'(1) << w) < span) w = w + 1;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mbi5153_line_map.sv
// Maps the transmit sequence position k to the physical line index.
// Sequential, reverse or even-then-odd interleave; mode 3 behaves as sequential.
module mbi5153_line_map
  import mbi5153_pkg::*;
#(
  parameter int SCAN_W = 5
) (
  input  logic [SCAN_W-1:0] K,
  input  logic [SCAN_W:0]   N,
  input  logic [1:0]        MODE,
  output logic [SCAN_W-1:0] LINE_IDX
);

  localparam int NW = SCAN_W + 1;

  logic [NW-1:0] k_ext;
  logic [NW-1:0] half_n;
  logic [NW-1:0] rev_v;
  logic [NW-1:0] ilv_v;

  always_comb begin
    k_ext  = {1'b0, K};
    half_n = (N + NW'(1)) >> 1;
    rev_v  = N - k_ext - NW'(1);
    // First ceil(N/2) positions walk the even lines, the rest the odd lines.
    if (k_ext < half_n) ilv_v = k_ext << 1;
    else                ilv_v = ((k_ext - half_n) << 1) | NW'(1);

    case (MODE)
      MODE_REV: LINE_IDX = SCAN_W'(rev_v);
      MODE_ILV: LINE_IDX = SCAN_W'(ilv_v);
      default:  LINE_IDX = K;
    endcase
  end

endmodule

// File: rtl/mbi5153_frame_seq.sv
// Frame sequencer for an MBI5153 panel: walks the lines of one frame, computing
// each line's external RAM base address and handshaking with the line transmitter.
module mbi5153_frame_seq
  import mbi5153_pkg::*;
#(
  parameter int EXT_RAM_BASE_ADDR = 0,
  parameter int IMG_WIDTH_MAX     = 64,
  parameter int SCAN_MAX          = 32,
  parameter int BANK_STRIDE       = IMG_WIDTH_MAX * SCAN_MAX,
  parameter int SCAN_W            = $clog2(SCAN_MAX),
  parameter int IMG_W             = $clog2(IMG_WIDTH_MAX + 1),
  parameter int ADDR_WIDTH        = addr_width_of(EXT_RAM_BASE_ADDR + 2 * BANK_STRIDE)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQUEST,
  input  logic                  ABORT,
  input  logic [SCAN_W-1:0]     SCAN_RATIO,
  input  logic [1:0]            MODE,
  input  logic                  BANK,
  input  logic [IMG_W-1:0]      IMG_WIDTH,
  input  logic                  LINE_READY,
  input  logic                  LINE_TX_DONE,
  output logic                  READY,
  output logic                  ACTIVE,
  output logic                  FRAME_TX_DONE,
  output logic                  ABORTED,
  output logic                  REQUEST_TO_SEND_LINE,
  output logic [SCAN_W-1:0]     LINE_IDX,
  output logic [ADDR_WIDTH-1:0] ADDR
);

  localparam int NW = SCAN_W + 1;
  localparam logic [IMG_W-1:0] WIDTH_CAP = IMG_W'(IMG_WIDTH_MAX);

  frame_state_t state;
  frame_state_t state_next;

  logic [SCAN_W-1:0] scan_ratio_q;
  logic [1:0]        mode_q;
  logic              bank_q;
  logic [IMG_W-1:0]  width_q;
  logic [SCAN_W-1:0] k;
  logic              abort_pending;

  logic              latch_cfg;
  logic              load_line;
  logic              k_inc;
  logic              set_pend;
  logic              abort_exit;

  logic [NW-1:0]     n_lines;
  logic [SCAN_W-1:0] map_idx;
  logic [63:0]       addr_full;

  assign n_lines = {1'b0, scan_ratio_q} + NW'(1);

  mbi5153_line_map #(
    .SCAN_W (SCAN_W)
  ) u_line_map (
    .K        (k),
    .N        (n_lines),
    .MODE     (mode_q),
    .LINE_IDX (map_idx)
  );

  // Wide intermediate so the final truncation to ADDR_WIDTH is the only wrap.
  assign addr_full = 64'(EXT_RAM_BASE_ADDR)
                   + (bank_q ? 64'(BANK_STRIDE) : 64'd0)
                   + 64'(map_idx) * 64'(width_q);

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch_cfg  = 1'b0;
    load_line  = 1'b0;
    k_inc      = 1'b0;
    set_pend   = 1'b0;
    abort_exit = 1'b0;

    case (state)
      ST_IDLE: begin
        if (REQUEST && !ABORT) begin
          state_next = ST_CALC;
          latch_cfg  = 1'b1;
        end
      end
      ST_CALC: begin
        load_line = 1'b1;
        if (ABORT) begin
          state_next = ST_IDLE;
          abort_exit = 1'b1;
        end else begin
          state_next = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (ABORT) begin
          state_next = ST_IDLE;
          abort_exit = 1'b1;
        end else if (LINE_READY) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ABORT) begin
          state_next = ST_IDLE;
          abort_exit = 1'b1;
        end else begin
          state_next = ST_WAIT_LINE;
        end
      end
      // An abort here lets the line in flight finish; it also beats the last-line done.
      ST_WAIT_LINE: begin
        if (LINE_TX_DONE) begin
          if (ABORT || abort_pending) begin
            state_next = ST_IDLE;
            abort_exit = 1'b1;
          end else if (k == scan_ratio_q) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CALC;
            k_inc      = 1'b1;
          end
        end else if (ABORT) begin
          set_pend = 1'b1;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    READY                = (state == ST_IDLE);
    FRAME_TX_DONE        = (state == ST_DONE);
    REQUEST_TO_SEND_LINE = (state == ST_ISSUE);
    ACTIVE               = (state == ST_CALC) || (state == ST_WAIT_RDY) ||
                           (state == ST_ISSUE) || (state == ST_WAIT_LINE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      scan_ratio_q  <= '0;
      mode_q        <= MODE_SEQ;
      bank_q        <= 1'b0;
      width_q       <= '0;
      k             <= '0;
      abort_pending <= 1'b0;
      ABORTED       <= 1'b0;
      LINE_IDX      <= '0;
      ADDR          <= ADDR_WIDTH'(EXT_RAM_BASE_ADDR);
    end else begin
      ABORTED <= abort_exit;

      if (latch_cfg) begin
        scan_ratio_q <= SCAN_RATIO;
        mode_q       <= MODE;
        bank_q       <= BANK;
        width_q      <= (IMG_WIDTH > WIDTH_CAP) ? WIDTH_CAP : IMG_WIDTH;
        k            <= '0;
      end else if (k_inc) begin
        k <= k + SCAN_W'(1);
      end

      if (load_line) begin
        LINE_IDX <= map_idx;
        ADDR     <= ADDR_WIDTH'(addr_full);
      end

      if (set_pend)                   abort_pending <= 1'b1;
      else if (state_next == ST_IDLE) abort_pending <= 1'b0;
    end
  end

endmodule
